npu_mem_master: RTL and testbench

- Initiator for the 32-bit SRAM-like word port used by the NPU buffer slave.
- Accepts one command at a time: start word address, word count and direction.
- Write commands move words from a valid/ready input stream into sequential zero-wait-state writes.
- Read commands issue sequential reads and return the 1-cycle-latency read data on a valid/ready output stream with backpressure; sits between the control/DMA logic and the axi2mem-style slave port.

---
 rtl/npu_mem_master.sv | 189 ++++++++++++++++++
 tb/tb_npu_mem_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_mem_master.sv
// npu_mem_master: single-command initiator for the NPU buffer word port (write stream -> writes, reads -> read stream).
// Latency: a write beat reaches the port in the same cycle; read data reaches rd_data 2 cycles after its request.
// Backpressure: wr_ready is low outside WRITE; read requests stall while the 2-entry return FIFO could overflow.
// Optional: define NPU_MEM_MASTER_BOUND_CHECK_EN to reject commands running past the top word (err pulse, no accesses).
module npu_mem_master #(
   parameter int AXI_WIDTH = 32,
   parameter int ADDR_W    = 3,
   parameter int LEN_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [ADDR_W-1:0]    cmd_addr,
   input  logic [LEN_W-1:0]     cmd_len,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [AXI_WIDTH-1:0] wr_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [AXI_WIDTH-1:0] rd_data,
   output logic                 busy,
   output logic                 done,
`ifdef NPU_MEM_MASTER_BOUND_CHECK_EN
   output logic                 err,
`endif
   output logic                 req_o,
   output logic [3:0]           wen_o,
   output logic [ADDR_W-1:0]    addr_o,
   output logic [AXI_WIDTH-1:0] wdata_o,
   input  logic [AXI_WIDTH-1:0] rdata_i
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   state_t                state;
   logic [ADDR_W-1:0]     ptr;
   logic [LEN_W-1:0]      remaining;

   logic [AXI_WIDTH-1:0]  fifo_mem [2];
   logic                  fifo_wp;
   logic                  fifo_rp;
   logic [1:0]            fifo_cnt;
   logic                  inflight;

   logic                  wr_beat;
   logic                  rd_issue;
   logic                  pop;
   logic                  push;
   logic                  drained;
   logic                  cmd_fire;
   logic                  cmd_oob;

   assign cmd_fire = cmd_valid && cmd_ready;
   assign wr_ready = (state == WRITE) && (remaining != '0);
   assign wr_beat  = wr_valid && wr_ready;
   assign pop      = rd_valid && rd_ready;
   assign push     = inflight;
   assign rd_valid = (fifo_cnt != 2'd0);
   assign rd_data  = rd_valid ? fifo_mem[fifo_rp] : '0;

   // A read may issue only if, after this cycle's pop, buffered plus in-flight words leave a free slot.
   assign rd_issue = (state == READ) && (remaining != '0) &&
                     (({1'b0, fifo_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

   assign req_o   = wr_beat || rd_issue;
   assign wen_o   = wr_beat ? 4'hF : 4'h0;
   assign addr_o  = req_o ? ptr : '0;
   assign wdata_o = wr_beat ? wr_data : '0;

   // Nothing left in flight and the FIFO empties at this edge.
   assign drained = !inflight && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

`ifdef NPU_MEM_MASTER_BOUND_CHECK_EN
   assign cmd_oob = (int'(cmd_addr) + int'(cmd_len)) > (1 << ADDR_W);
`else
   assign cmd_oob = 1'b0;
`endif

   // Command FSM: owns pointer/remaining and the registered handshake/status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_fire) begin
                  ptr       <= cmd_addr;
                  remaining <= cmd_len;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if ((cmd_len == '0) || cmd_oob) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (cmd_write) begin
                     state <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            WRITE: begin
               if (wr_beat) begin
                  ptr       <= ptr + ADDR_W'(1);
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            READ: begin
               if (rd_issue) begin
                  ptr       <= ptr + ADDR_W'(1);
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drained) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-return path: in-flight flag tracks the 1-cycle memory latency, 2-entry FIFO buffers for backpressure.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         fifo_wp     <= 1'b0;
         fifo_rp     <= 1'b0;
         fifo_cnt    <= 2'd0;
         inflight    <= 1'b0;
      end else begin
         inflight <= rd_issue;
         if (push) begin
            fifo_mem[fifo_wp] <= rdata_i;
            fifo_wp           <= ~fifo_wp;
         end
         if (pop) begin
            fifo_rp <= ~fifo_rp;
         end
         if (push && !pop) begin
            fifo_cnt <= fifo_cnt + 2'd1;
         end else if (!push && pop) begin
            fifo_cnt <= fifo_cnt - 2'd1;
         end
      end
   end

`ifdef NPU_MEM_MASTER_BOUND_CHECK_EN
   // err flags the DONE cycle of a rejected out-of-range command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else begin
         err <= cmd_fire && cmd_oob;
      end
   end
`endif

   // The issue rule must keep the return FIFO within its two entries.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(push && !pop && (fifo_cnt == 2'd2)));
      end
   end

endmodule

// File: tb/tb_npu_mem_master.sv
// tb_npu_mem_master: directed vector table plus hand sequences for backpressured reads and mid-command reset.
module tb_npu_mem_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [2:0]  cmd_addr;
   logic [7:0]  cmd_len;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid, rd_ready;
   logic [31:0] rd_data;
   logic        busy, done, err;
   logic        req_o;
   logic [3:0]  wen_o;
   logic [2:0]  addr_o;
   logic [31:0] wdata_o, rdata_i;
   logic [31:0] rdata_q = '0;

   npu_mem_master dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .done(done),
`ifdef NPU_MEM_MASTER_BOUND_CHECK_EN
      .err(err),
`endif
      .req_o(req_o), .wen_o(wen_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
   );

`ifndef NPU_MEM_MASTER_BOUND_CHECK_EN
   assign err = 1'b0;
`endif

   always #5 clk = ~clk;

   // Memory model: read of word a returns 0xA0+a one cycle later.
   always @(posedge clk) begin
      if (req_o && (wen_o == 4'h0)) rdata_q <= 32'hA0 + 32'(addr_o);
   end
   assign rdata_i = rdata_q;

   typedef struct packed {
      logic        req;
      logic [3:0]  wen;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic        wrr;
      logic        rdv;
      logic [31:0] rdd;
      logic        dn;
      logic        bz;
      logic        cr;
      logic        er;
   } obs_t;

   typedef struct {
      logic        cv;
      logic        cw;
      logic [2:0]  ca;
      logic [7:0]  cl;
      logic        wv;
      logic [31:0] wd;
      logic        rr;
      obs_t        exp;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic obs_t mk(input int req, input int wen, input int addr, input logic [31:0] wd,
                               input int wrr, input int rdv, input logic [31:0] rdd,
                               input int dn, input int bz, input int cr, input int er);
      obs_t o;
      o.req = req[0]; o.wen = wen[3:0]; o.addr = addr[2:0]; o.wdata = wd;
      o.wrr = wrr[0]; o.rdv = rdv[0]; o.rdd = rdd;
      o.dn = dn[0]; o.bz = bz[0]; o.cr = cr[0]; o.er = er[0];
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.req = req_o; o.wen = wen_o; o.addr = addr_o; o.wdata = wdata_o;
      o.wrr = wr_ready; o.rdv = rd_valid; o.rdd = rd_data;
      o.dn = done; o.bz = busy; o.cr = cmd_ready; o.er = err;
      return o;
   endfunction

   function automatic obs_t idle_o();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
   endfunction
   function automatic obs_t done_o();
      return mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
   endfunction
   function automatic obs_t wbeat(input int a, input logic [31:0] d);
      return mk(1, 4'hF, a, d, 1, 0, 0, 0, 1, 0, 0);
   endfunction
   function automatic obs_t wgap();
      return mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
   endfunction
   function automatic obs_t rdo(input int req, input int a, input int rdv, input logic [31:0] d);
      return mk(req, 0, a, 0, 0, rdv, d, 0, 1, 0, 0);
   endfunction

   task automatic add(input int cv, input int cw, input int ca, input int cl,
                      input int wv, input logic [31:0] wd, input int rr, input obs_t e);
      vec_t v;
      v.cv = cv[0]; v.cw = cw[0]; v.ca = ca[2:0]; v.cl = cl[7:0];
      v.wv = wv[0]; v.wd = wd; v.rr = rr[0]; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   initial begin
      int issued, popped, k, w;
      bit seen_done;

      // Write addr0 len5, wr_valid held high
      add(1, 1, 0, 5, 1, 'h11, 1, idle_o());
      add(0, 0, 0, 0, 1, 'h11, 1, wbeat(0, 'h11));
      add(0, 0, 0, 0, 1, 'h22, 1, wbeat(1, 'h22));
      add(0, 0, 0, 0, 1, 'h33, 1, wbeat(2, 'h33));
      add(0, 0, 0, 0, 1, 'h44, 1, wbeat(3, 'h44));
      add(0, 0, 0, 0, 1, 'h55, 1, wbeat(4, 'h55));
      add(0, 0, 0, 0, 1, 'h66, 1, done_o());
      add(0, 0, 0, 0, 0, 0,    1, idle_o());
      // Write addr2 len3, wr_valid 1,0,1,0,1
      add(1, 1, 2, 3, 0, 0,      1, idle_o());
      add(0, 0, 0, 0, 1, 'h1001, 1, wbeat(2, 'h1001));
      add(0, 0, 0, 0, 0, 'h9999, 1, wgap());
      add(0, 0, 0, 0, 1, 'h1002, 1, wbeat(3, 'h1002));
      add(0, 0, 0, 0, 0, 'h9999, 1, wgap());
      add(0, 0, 0, 0, 1, 'h1003, 1, wbeat(4, 'h1003));
      add(0, 0, 0, 0, 0, 0,      1, done_o());
      add(0, 0, 0, 0, 0, 0,      1, idle_o());
      // Read addr0 len4, rd_ready high
      add(1, 0, 0, 4, 0, 0, 1, idle_o());
      add(0, 0, 0, 0, 0, 0, 1, rdo(1, 0, 0, 0));
      add(0, 0, 0, 0, 0, 0, 1, rdo(1, 1, 0, 0));
      add(0, 0, 0, 0, 0, 0, 1, rdo(1, 2, 1, 'hA0));
      add(0, 0, 0, 0, 0, 0, 1, rdo(1, 3, 1, 'hA1));
      add(0, 0, 0, 0, 0, 0, 1, rdo(0, 0, 1, 'hA2));
      add(0, 0, 0, 0, 0, 0, 1, rdo(0, 0, 1, 'hA3));
      add(0, 0, 0, 0, 0, 0, 1, done_o());
      add(0, 0, 0, 0, 0, 0, 1, idle_o());
      // Write addr6 len4: wraps, or is rejected when bound checking is built in
      add(1, 1, 6, 4, 1, 'h61, 1, idle_o());
`ifdef NPU_MEM_MASTER_BOUND_CHECK_EN
      add(0, 0, 0, 0, 1, 'h61, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
      add(0, 0, 0, 0, 0, 0,    1, idle_o());
`else
      add(0, 0, 0, 0, 1, 'h61, 1, wbeat(6, 'h61));
      add(0, 0, 0, 0, 1, 'h62, 1, wbeat(7, 'h62));
      add(0, 0, 0, 0, 1, 'h63, 1, wbeat(0, 'h63));
      add(0, 0, 0, 0, 1, 'h64, 1, wbeat(1, 'h64));
      add(0, 0, 0, 0, 1, 'h65, 1, done_o());
      add(0, 0, 0, 0, 0, 0,    1, idle_o());
`endif

      // Reset
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", observe(), '0);
      reset = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw; cmd_addr = vecs[i].ca; cmd_len = vecs[i].cl;
         wr_valid = vecs[i].wv; wr_data = vecs[i].wd; rd_ready = vecs[i].rr;
         @(negedge clk);
         check($sformatf("vec%0d", i), observe(), vecs[i].exp);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0; wr_valid = 1'b0;

      // Read addr2 len6 with rd_ready low for cycles 3-7 after acceptance
      issued = 0; popped = 0; k = 0; seen_done = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2; cmd_len = 8'd6;
      while (!seen_done && k < 60) begin
         rd_ready = !(k >= 3 && k <= 7);
         @(negedge clk);
         if (k == 5) check1("bp_stall_req", 32'(req_o), 0);
         if (req_o) begin
            check1("bp_addr", 32'(addr_o), 32'(2 + issued));
            issued++;
         end
         if (rd_valid && rd_ready) begin
            check1("bp_data", rd_data, 32'hA2 + 32'(popped));
            popped++;
         end
         check1("bp_outstanding_le2", 32'(issued - popped <= 2), 1);
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         k++;
      end
      check1("bp_done_seen", 32'(seen_done), 1);
      check1("bp_issued", 32'(issued), 6);
      check1("bp_popped", 32'(popped), 6);

      // Reset in READ with two words buffered
      rd_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_len = 8'd4;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      check1("pre_rst_rd_valid", 32'(rd_valid), 1);
      check1("pre_rst_req_stalled", 32'(req_o), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check1("rst_rd_valid", 32'(rd_valid), 0);
      check1("rst_busy", 32'(busy), 0);
      check1("rst_done", 32'(done), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      rd_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check1("post_rst_no_done", 32'(done), 0);
         @(posedge clk); #1;
      end
      w = 0;
      while (!cmd_ready && w < 10) begin
         @(posedge clk); #1;
         w++;
      end
      check1("post_rst_cmd_ready", 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd3; cmd_len = 8'd0;
      @(negedge clk);
      check1("len0_accept_busy", 32'(busy), 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check1("len0_done", {30'd0, done, busy}, 32'h3);
      @(posedge clk); #1;
      @(negedge clk);
      check1("len0_after", {29'd0, done, busy, cmd_ready}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
